// File: rtl/seg7_pkg.sv
// Shared constants and types for the 8-digit seven-segment scan driver.
package seg7_pkg;

    localparam int         NUM_DIGITS = 8;
    localparam logic [6:0] SEG_OFF    = 7'h7F;
    localparam logic [7:0] AN_OFF     = 8'hFF;

    typedef logic [2:0] digit_idx_t;

    // Active-low {CA..CG} patterns for hex digits 0..F.
    localparam logic [6:0] HEX7 [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational nibble to active-low seven-segment pattern.
module hex_to_7seg
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX7[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 8-digit common-anode display driver with frame-coherent
// snapshot, per-digit enable and optional leading-zero blanking.
//
// state (idx) | meaning
// 0..7        | digit idx is being refreshed; advances when div hits its last count
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] value,
    input  logic [7:0]  digit_en,
    input  logic        blank_lz,
    output logic [6:0]  segments,
    output logic [7:0]  anodos
);

    localparam int               DIV_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    digit_idx_t       idx_q, idx_d;
    logic [31:0]      snap_q, snap_d;
    logic [6:0]       seg_q, seg_d;
    logic [7:0]       an_q, an_d;

    logic             div_wrap;
    logic [7:0]       lead_zero;
    logic             dark;
    logic [3:0]       cur_nibble;
    logic [6:0]       cur_code;

    assign cur_nibble = snap_q[{idx_q, 2'b00} +: 4];

    hex_to_7seg u_hex_to_7seg (
        .nibble (cur_nibble),
        .seg    (cur_code)
    );

    always_comb begin
        div_wrap = (div_q == DIV_LAST);
        div_d    = div_wrap ? '0 : div_q + DIV_W'(1);
        idx_d    = div_wrap ? idx_q + digit_idx_t'(1) : idx_q;
        // New value is only taken at the frame boundary so a frame never tears.
        snap_d   = (div_wrap && idx_q == digit_idx_t'(NUM_DIGITS - 1)) ? value : snap_q;

        // Digit 0 always stays lit under the leading-zero rule.
        lead_zero = '0;
        for (int k = 1; k < NUM_DIGITS; k++) begin
            lead_zero[k] = ((snap_q >> (4 * k)) == 32'd0);
        end

        dark = !digit_en[idx_q] || (blank_lz && lead_zero[idx_q]);
        an_d  = dark ? AN_OFF  : ~(8'b1 << idx_q);
        seg_d = dark ? SEG_OFF : cur_code;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            div_q  <= '0;
            idx_q  <= '0;
            snap_q <= '0;
            seg_q  <= SEG_OFF;
            an_q   <= AN_OFF;
        end else begin
            div_q  <= div_d;
            idx_q  <= idx_d;
            snap_q <= snap_d;
            seg_q  <= seg_d;
            an_q   <= an_d;
        end
    end

    assign segments = seg_q;
    assign anodos   = an_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver against a cycle-count reference model.
module tb_seg7_scan_driver;

    localparam int RDIV  = 4;
    localparam int FRAME = 8 * RDIV;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] value = 32'h0;
    logic [7:0]  digit_en = 8'hFF;
    logic        blank_lz = 1'b0;
    logic [6:0]  segments;
    logic [7:0]  anodos;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    // Reference state: edges since reset released and the value of the frame on display.
    int          cyc = 0;
    logic [31:0] m_snap = 32'h0;
    logic [6:0]  exp_seg;
    logic [7:0]  exp_an;

    logic [6:0] hex_ref [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    seg7_scan_driver #(.REFRESH_DIV(RDIV)) dut (
        .clock    (clock),
        .reset    (reset),
        .value    (value),
        .digit_en (digit_en),
        .blank_lz (blank_lz),
        .segments (segments),
        .anodos   (anodos)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (chk_en) begin
            vectors++;
            assert ($countones(~anodos) <= 1) else begin
                miscompares++;
                $error("FAIL one_hot_anodos t=%0t observed=%h required=at most one low bit", $time, anodos);
            end
        end
    end

    task automatic tick();
        int  d;
        bit  lz;
        if (reset) begin
            exp_an  = 8'hFF;
            exp_seg = 7'h7F;
        end else begin
            d  = (cyc / RDIV) % 8;
            lz = (d != 0) && ((m_snap >> (4 * d)) == 32'd0);
            if (!digit_en[d] || (blank_lz && lz)) begin
                exp_an  = 8'hFF;
                exp_seg = 7'h7F;
            end else begin
                exp_an  = ~(8'h01 << d);
                exp_seg = hex_ref[(m_snap >> (4 * d)) & 32'hF];
            end
        end
        @(posedge clock);
        #1;
        if (reset) begin
            cyc    = 0;
            m_snap = 32'h0;
        end else begin
            if (cyc % FRAME == FRAME - 1) m_snap = value;
            cyc++;
        end
        vectors++;
        assert (anodos === exp_an) else begin
            miscompares++;
            $error("FAIL anodos cyc=%0d observed=%h expected=%h", cyc, anodos, exp_an);
        end
        vectors++;
        assert (segments === exp_seg) else begin
            miscompares++;
            $error("FAIL segments cyc=%0d observed=%b expected=%b", cyc, segments, exp_seg);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Advance until the next edge lands at the given phase inside a frame.
    task automatic run_to_phase(input int ph);
        for (int i = 0; i < FRAME && (cyc % FRAME) != ph; i++) tick();
    endtask

    initial begin
        // Reset and all-zero scan
        reset = 1'b1;
        run(3);
        chk_en = 1'b1;
        reset = 1'b0;
        run(40);

        // Mixed hex digits across two frames
        value = 32'h1234_ABCD;
        run(2 * FRAME);

        // Mid-frame change does not tear the display
        value = 32'h1111_1111;
        run_to_phase(0);
        run(FRAME);
        run_to_phase(3 * RDIV);
        value = 32'h2222_2222;
        run(2 * FRAME);

        // Leading-zero blanking
        blank_lz = 1'b1;
        value = 32'h0000_00A0;
        run(2 * FRAME + 5);
        value = 32'h0;
        run(2 * FRAME);

        // Per-digit enable mask
        blank_lz = 1'b0;
        digit_en = 8'b0000_0101;
        value = 32'h9876_5432;
        run(2 * FRAME);

        // Randomized inputs
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) value = $urandom;
            if ($urandom_range(0, 31) == 0) digit_en = 8'($urandom);
            if ($urandom_range(0, 31) == 0) blank_lz = 1'($urandom);
            if ($urandom_range(0, 3) == 0) value = value & ~(32'hFFFF_FFFF << (4 * $urandom_range(0, 7)));
            tick();
        end

        // Reset pulse in the middle of digit 5
        digit_en = 8'hFF;
        blank_lz = 1'b0;
        value = 32'hFEDC_BA98;
        run_to_phase(5 * RDIV + 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        run(3 * FRAME);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed driver for the board's 8-digit common-anode seven-segment display. It sits directly downstream of the counter/ALU datapath and converts a 32-bit value (8 hex nibbles) into the `segments`/`anodos` pin pattern, scanning one digit at a time. It also provides a per-digit enable mask, optional leading-zero blanking, and a frame-coherent snapshot of the input value.

## Interface
- `REFRESH_DIV`, default 100000: clock cycles each digit is lit (1 ms at 100 MHz); minimum 2.
- `clock`  in  1  system clock (100 MHz on board).
- `reset`  in  1  reset; one clock domain, synchronous, active-high.
- `value`  in  32  hex value to display; nibble k drives digit k (digit 0 = rightmost, AN0).
- `digit_en`  in  8  per-digit enable; 0 forces that digit dark.
- `blank_lz`  in  1  1 = blank leading zero digits (digit 0 is never blanked by this rule).
- `segments`  out  7  {CA,CB,CC,CD,CE,CF,CG}, active-low.
- `anodos`  out  8  {AN7..AN0}, active-low; at most one bit low at any time.

## Operation
- Divider `div` counts 0..REFRESH_DIV-1 and wraps. Digit index `idx` (3 bits) increments when `div == REFRESH_DIV-1`, wrapping 7 -> 0.
- Snapshot register `snap` (32 bits) loads `value` when `div == REFRESH_DIV-1` and `idx == 7`. A whole 8-digit frame therefore always shows one coherent value. Input changes mid-frame never tear the display.
- `digit_en` and `blank_lz` are sampled live every cycle and are not snapshotted.
- Leading-zero rule, computed from `snap`: digit k is a leading zero if nibbles 7..k of `snap` are all 0 and k != 0.
- Digit k is dark if `digit_en[k]==0`, or if `blank_lz==1` and k is a leading zero. A dark digit drives `anodos = 8'hFF` and `segments = 7'h7F`.
- Otherwise `anodos = ~(8'b1 << idx)` and `segments = hex7(snap[4*idx +: 4])`.
- hex7 codes (CA..CG, active-low):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- State machine: scan state is `idx`; transitions only as described above. There are no other states.

## Timing
- Reset values: `div=0`, `idx=0`, `snap=0`, `anodos=8'hFF`, `segments=7'h7F`.
- `segments` and `anodos` are registered and lag `idx`/`snap` by exactly one clock.
- First clock edge with `reset` low: outputs show digit 0 of `snap=0`, i.e. `anodos=8'hFE`, `segments=7'b0000001` (provided `digit_en[0]=1`).
- Each digit is held for exactly REFRESH_DIV cycles. A full frame is 8·REFRESH_DIV cycles.
- The first frame after reset always shows 0. A `value` applied after reset appears at the start of the second frame.
- Latency from `value` to pins: between 1 and 8·REFRESH_DIV+1 cycles, depending on frame phase.
- `reset` asserted mid-scan: on the next edge all state returns to reset values, with no partial frame completion.
- `anodos` never has two bits low, including on wrap and on the reset edges.

## Structure
- Package `seg7_pkg`:
  - `NUM_DIGITS = 8`
  - `SEG_OFF = 7'h7F`
  - `AN_OFF = 8'hFF`
  - hex7 code constants array `HEX7[16]`
  - typedef `digit_idx_t` (logic [2:0])
- Sub-module `hex_to_7seg` (combinational nibble -> 7-bit active-low code, using `HEX7`). It is instantiated once, fed by the mux selecting `snap[4*idx +: 4]`.
- Top contains the divider, index counter, snapshot, leading-zero logic and output registers.

## Test plan
Bench uses REFRESH_DIV=4 and `clock` period 10 ns.
- Reset, then `value=32'h0000_0000`, `digit_en=8'hFF`, `blank_lz=0` -> `anodos` steps FE, FD, FB, …, 7F every 4 cycles with `segments=0000001` throughout, then wraps to FE.
- `value=32'h1234_ABCD` held through two frames -> second frame, digit 0..7 shows: d=1000010, C=0110001, b=1100000, A=0001000, 4=1001100, 3=0000110, 2=0010010, 1=1001111.
- Change `value` from `32'h1111_1111` to `32'h2222_2222` while `idx=3` -> remainder of that frame still shows 1 (`1001111`); the next frame shows 2 (`0010010`) on all digits.
- `value=32'h0000_00A0`, `blank_lz=1` -> digits 0,1 lit (0=0000001, A=0001000); digits 2..7 drive `anodos=FF`, `segments=7F`. With `value=0`, only digit 0 is lit and shows 0.
- `digit_en=8'b0000_0101` -> only digits 0 and 2 ever pull an anode low; the other slots drive `anodos=FF` for 4 cycles each.
- Assert `reset` for 1 cycle while `idx=5` -> next edge `anodos=FF`, `segments=7F`; the following edge starts at `anodos=FE`. A concurrent check asserts at most one `anodos` bit is low on every cycle.
